// File: rtl/whack_round_ctrl.sv
// whack_round_ctrl
//   Game-round controller for a whack-a-mole style game. It shows a one-hot
//   target on the LEDs, grades debounced button pulses as hits or misses,
//   keeps score, misses and difficulty level, and drives the speed timer.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous, active-low reset
//   start      in   one-cycle pulse, begins a new game from IDLE or OVER
//   timeout    in   one-cycle pulse from the speed timer (target window expired)
//   btn[3:0]   in   debounced one-cycle button pulses, one bit per LED
//   enable     out  run request to the speed timer
//   speed[1:0] out  difficulty level: 0 slow, 1 mid, 2 fast
//   led[3:0]   out  target display (one-hot in play, all on at game over)
//   score[7:0] out  hit count, saturating at 255
//   misses[2:0] out miss count
//   game_over  out  high while in OVER
module whack_round_ctrl #(
    parameter int unsigned LIVES          = 3,
    parameter int unsigned HITS_PER_LEVEL = 5,
    parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       timeout,
    input  logic [3:0] btn,
    output logic       enable,
    output logic [1:0] speed,
    output logic [3:0] led,
    output logic [7:0] score,
    output logic [2:0] misses,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHOW,
        S_WAIT,
        S_GAP,
        S_OVER
    } state_t;

    state_t     state, state_n;

    logic [7:0] lfsr, lfsr_n;
    logic [3:0] hit_cnt, hit_cnt_n;
    logic       enable_n;
    logic [1:0] speed_n;
    logic [3:0] led_n;
    logic [7:0] score_n;
    logic [2:0] misses_n;
    logic       game_over_n;

    logic       hit, miss;
    logic [2:0] misses_inc;
    logic [3:0] hit_inc;
    logic       lfsr_fb;

    // A button pulse always takes priority over a timeout in the same cycle.
    assign hit        = (btn != 4'd0) && (btn == led);
    assign miss       = ((btn != 4'd0) && (btn != led)) || ((btn == 4'd0) && timeout);
    assign misses_inc = misses + 3'd1;
    assign hit_inc    = hit_cnt + 4'd1;
    // x^8 + x^6 + x^5 + x^4 + 1
    assign lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (start) state_n = S_SHOW;
            S_SHOW: state_n = S_WAIT;
            S_WAIT: begin
                if (hit)       state_n = S_GAP;
                else if (miss) state_n = (misses_inc == 3'(LIVES)) ? S_OVER : S_GAP;
            end
            S_GAP:  state_n = S_SHOW;
            S_OVER: if (start) state_n = S_SHOW;
            default: state_n = S_IDLE;
        endcase
    end

    // Output logic: computes the next value of every registered output, keyed
    // on the current state, so the outputs change on the transition edge.
    always_comb begin
        lfsr_n      = lfsr;
        hit_cnt_n   = hit_cnt;
        enable_n    = enable;
        speed_n     = speed;
        led_n       = led;
        score_n     = score;
        misses_n    = misses;
        game_over_n = game_over;
        case (state)
            S_IDLE, S_OVER: begin
                if (start) begin
                    score_n     = '0;
                    misses_n    = '0;
                    speed_n     = '0;
                    hit_cnt_n   = '0;
                    lfsr_n      = LFSR_SEED;
                    led_n       = '0;
                    enable_n    = 1'b0;
                    game_over_n = 1'b0;
                end
            end
            S_SHOW: begin
                case (lfsr[1:0])
                    2'b00:   led_n = 4'b0001;
                    2'b01:   led_n = 4'b0010;
                    2'b10:   led_n = 4'b0100;
                    default: led_n = 4'b1000;
                endcase
                lfsr_n   = {lfsr[6:0], lfsr_fb};
                enable_n = 1'b1;
            end
            S_WAIT: begin
                if (hit) begin
                    score_n = (score == 8'hFF) ? score : score + 8'd1;
                    if (hit_inc == 4'(HITS_PER_LEVEL)) begin
                        hit_cnt_n = '0;
                        if (speed < 2'd2) speed_n = speed + 2'd1;
                    end else begin
                        hit_cnt_n = hit_inc;
                    end
                    led_n    = '0;
                    enable_n = 1'b0;
                end else if (miss) begin
                    misses_n  = misses_inc;
                    hit_cnt_n = '0;
                    enable_n  = 1'b0;
                    if (misses_inc == 3'(LIVES)) begin
                        led_n       = 4'hF;
                        game_over_n = 1'b1;
                    end else begin
                        led_n = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr      <= LFSR_SEED;
            hit_cnt   <= '0;
            enable    <= 1'b0;
            speed     <= '0;
            led       <= '0;
            score     <= '0;
            misses    <= '0;
            game_over <= 1'b0;
        end else begin
            lfsr      <= lfsr_n;
            hit_cnt   <= hit_cnt_n;
            enable    <= enable_n;
            speed     <= speed_n;
            led       <= led_n;
            score     <= score_n;
            misses    <= misses_n;
            game_over <= game_over_n;
        end
    end

endmodule

// File: doc/whack_round_ctrl.md
Name: whack_round_ctrl

Overview:
- Game-round controller downstream of the speed timer; consumes its one-cycle `timeout` pulse.
- Drives one-hot target LEDs and grades debounced player button pulses as hit or miss.
- Keeps score, misses and difficulty level, and feeds `enable` and `speed` back to the timer.
- Sits between the button one-shot/debounce stage and the LED/score display stage.

Parameters:
- LIVES, 3: misses allowed before game over; range 1..7.
- HITS_PER_LEVEL, 5: consecutive-level hits needed to raise speed; range 1..15.
- LFSR_SEED, 8'hA5: nonzero LFSR load value applied on each game start.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a new game from IDLE or OVER.
- timeout  in  1  one-cycle pulse from the speed timer; target window expired.
- btn  in  4  debounced one-cycle button pulses, one bit per LED.
- enable  out  1  run request to the speed timer.
- speed  out  2  difficulty level to the speed timer: 0 slow, 1 mid, 2 fast.
- led  out  4  target display.
- score  out  8  hit count, saturating.
- misses  out  3  miss count.
- game_over  out  1  high while in OVER.

Behaviour:
- Reset (rst==0 at posedge clk):
  - state=IDLE.
  - enable=0, speed=0, led=0, score=0, misses=0, game_over=0.
  - Internal hit_cnt=0; lfsr=LFSR_SEED.
  - Reset mid-game aborts immediately; no pending event survives.
- All outputs are registered.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances only on SHOW entry. Never zero: LFSR_SEED must be nonzero.
- IDLE:
  - led=0, enable=0.
  - start=1 → score=0, misses=0, speed=0, hit_cnt=0, lfsr=LFSR_SEED → SHOW.
- SHOW (1 cycle):
  - led <= one-hot of lfsr[1:0] (00→0001, 01→0010, 10→0100, 11→1000).
  - lfsr advances; enable <= 1 → WAIT.
- WAIT (enable=1, led held):
  - Priority: btn over timeout. A btn pulse and a timeout in the same cycle grade as the btn.
  - Hit: btn != 0 and btn == led.
    - score += 1, saturating at 255; hit_cnt += 1.
    - If the new hit_cnt == HITS_PER_LEVEL: if speed<2, speed += 1; hit_cnt=0 regardless.
    - → GAP.
  - Miss: btn != 0 and btn != led (a wrong button or multiple buttons), or btn == 0 and timeout == 1.
    - misses += 1; hit_cnt=0; speed is unchanged.
    - If the new misses == LIVES → OVER, else → GAP.
  - Otherwise stay in WAIT.
- GAP (1 cycle):
  - led=0, enable=0 → SHOW.
  - The enable low pulse forces the timer to stop and restart its count on re-enable.
- OVER:
  - led=4'hF, enable=0, game_over=1.
  - score, misses and speed are held.
  - start=1 → same initialisation as IDLE → SHOW; game_over clears on that edge.
- Ignored inputs:
  - timeout outside WAIT.
  - btn outside WAIT.
  - start outside IDLE/OVER.
- Latency:
  - btn/timeout sampled at edge N → score/misses updated and led=0 at edge N+1.
  - New target at edge N+3.
- The speed change takes effect at the timer's next enable.

Test Plan:
- Reset with rst=0 for 2 cycles → all outputs 0, state IDLE; timeout pulses give no output change.
- start pulse → led=0010 after 2 cycles (seed A5, lfsr[1:0]=01), enable=1, speed=0; btn=0010 → score=1, led=0 next cycle, new one-hot target 2 cycles later.
- Five consecutive correct hits → speed=1; ten more → speed=2; five further hits → speed stays 2, score=20.
- Three timeouts with no btn → misses=3, game_over=1, led=F, enable=0; later btn and timeout pulses change nothing; start → score=0, misses=0, game_over=0.
- Same-cycle correct btn and timeout → graded hit (score+1, misses unchanged); btn=0011 with led=0001 → miss.
- Drive score to 255 by forced hits → further hits keep score=255; rst=0 in WAIT → led=0, enable=0, state IDLE next edge.
